// File: rtl/spi_word_slave.sv
// SPI mode-0 word responder; optional end-of-stream detect under SPI_SLAVE_EOS_DETECT_EN.
// Latency: rx_valid and miso updates land SYNC_STAGES+2 clk edges after the raw sck edge.
// Backpressure: none on receive; transmit loads zeros and flags tx_underrun when tx_valid is low.
module spi_word_slave #(
  parameter int WORD_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck_in,
  input  logic                  ss_in,
  input  logic                  mosi,
  output logic                  miso,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  frame_err,
  output logic                  busy,
  output logic                  eos
);

  localparam int CW = $clog2(WORD_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sync;
  logic [SYNC_STAGES-1:0]  ss_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sck_d;
  logic                    ss_d;
  logic                    sck_rise;
  logic                    sck_fall;
  logic                    ss_fall;
  logic                    ss_rise;
  logic                    mosi_bit;
  logic [CW-1:0]           bit_cnt;
  logic                    word_done;
  logic [WORD_WIDTH-2:0]   rx_shift;
  logic [WORD_WIDTH-1:0]   tx_shift;
  logic [WORD_WIDTH-1:0]   rx_word;
  logic [WORD_WIDTH-1:0]   load_val;

  // Synchronizers are left out of reset so a held-low ss_in never looks like a fresh select.
  always_ff @(posedge clk) begin
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    sck_d     <= sck_sync[SYNC_STAGES-1];
    ss_d      <= ss_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      ss_fall  <= 1'b0;
      ss_rise  <= 1'b0;
      mosi_bit <= 1'b0;
    end else begin
      sck_rise <= sck_sync[SYNC_STAGES-1] & ~sck_d;
      sck_fall <= ~sck_sync[SYNC_STAGES-1] & sck_d;
      ss_fall  <= ~ss_sync[SYNC_STAGES-1] & ss_d;
      ss_rise  <= ss_sync[SYNC_STAGES-1] & ~ss_d;
      mosi_bit <= mosi_sync[SYNC_STAGES-1];
    end
  end

  assign rx_word  = {rx_shift, mosi_bit};
  assign load_val = tx_valid ? tx_data : '0;
  assign miso     = tx_shift[WORD_WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef SPI_SLAVE_EOS_DETECT_EN
      eos         <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SPI_SLAVE_EOS_DETECT_EN
      eos         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state       <= SHIFT;
            busy        <= 1'b1;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            tx_shift    <= load_val;
            tx_ready    <= tx_valid;
            tx_underrun <= ~tx_valid;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tx_shift  <= '0;
            bit_cnt   <= '0;
            frame_err <= (bit_cnt != '0);
          end else if (sck_rise) begin
            rx_shift <= rx_word[WORD_WIDTH-2:0];
            if (bit_cnt == CW'(WORD_WIDTH - 1)) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
`ifdef SPI_SLAVE_EOS_DETECT_EN
              if (&rx_word) begin
                eos <= 1'b1;
              end else begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
              end
`else
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (sck_fall) begin
            // The fall right after a completed word is where the next outgoing word is fetched.
            if (bit_cnt == '0 && word_done) begin
              tx_shift    <= load_val;
              tx_ready    <= tx_valid;
              tx_underrun <= ~tx_valid;
            end else begin
              tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPI_SLAVE_EOS_DETECT_EN
  assign eos = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_slave.sv
// Directed bench for spi_word_slave: SPI master model plus pulse counters on the word side.
module tb_spi_word_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck_in;
  logic        ss_in;
  logic        mosi;
  logic        miso;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_underrun;
  logic        frame_err;
  logic        busy;
  logic        eos;

  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0, rdy_cnt = 0, und_cnt = 0, ferr_cnt = 0, eos_cnt = 0;
  logic [31:0] rxq[$];

  spi_word_slave #(.WORD_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck_in(sck_in), .ss_in(ss_in), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy), .eos(eos)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rxq.push_back(rx_data);
    end
    if (tx_ready)    rdy_cnt++;
    if (tx_underrun) und_cnt++;
    if (frame_err)   ferr_cnt++;
    if (eos)         eos_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master shifts out nbits MSB-first and captures miso just before each rise.
  task automatic spi_bits(input logic [31:0] d, input int nbits, input int half, output logic [31:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[31-i];
      tick(half);
      rd = {rd[30:0], miso};
      sck_in = 1'b1;
      tick(half);
      sck_in = 1'b0;
    end
  endtask

  task automatic frame1(input logic [31:0] d, input int half);
    logic [31:0] r;
    ss_in = 1'b0;
    tick(half);
    spi_bits(d, 32, half, r);
    tick(half);
    ss_in = 1'b1;
    tick(8);
  endtask

  initial begin
    logic [31:0] r0, r1;
    logic [31:0] words [10];
    int b_rx, b_rdy, b_und, b_ferr, b_eos, b_q;

    reset = 1'b1; sck_in = 1'b0; ss_in = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    tick(3);
    check("reset_rx_data", rx_data, 32'h0);
    check("reset_flags", {25'b0, miso, rx_valid, tx_ready, tx_underrun, frame_err, busy, eos}, 32'h0);
    reset = 1'b0;
    tick(4);

    // Single word at sck = clk/4
    b_rx = rx_cnt;
    frame1(32'h12345678, 2);
    check("single_rx_count", rx_cnt - b_rx, 1);
    check("single_rx_word", rxq[$], 32'h12345678);
    tick(20);
    check("single_rx_hold", rx_data, 32'h12345678);
    check("single_busy_after", {31'b0, busy}, 0);

    // Two-word exchange: underrun at select, then tx_data in word 1
    b_rx = rx_cnt; b_rdy = rdy_cnt; b_und = und_cnt;
    tx_data = 32'hA5A5_0F0F;
    ss_in = 1'b0;
    tick(6);
    check("tx_underrun_at_select", und_cnt - b_und, 1);
    check("tx_busy_in_frame", {31'b0, busy}, 1);
    tx_valid = 1'b1;
    spi_bits(32'hCAFEBABE, 32, 6, r0);
    tick(6);
    tx_valid = 1'b0;
    spi_bits(32'h01020304, 32, 6, r1);
    tick(6);
    ss_in = 1'b1;
    tick(8);
    check("tx_word0_miso", r0, 32'h0);
    check("tx_word1_miso", r1, 32'hA5A50F0F);
    check("tx_ready_count", rdy_cnt - b_rdy, 1);
    check("tx_underrun_total", und_cnt - b_und, 2);
    check("tx_rx_count", rx_cnt - b_rx, 2);
    check("tx_rx_word0", rxq[$-1], 32'hCAFEBABE);
    check("tx_rx_word1", rxq[$], 32'h01020304);

    // Ten back-to-back words under one select
    b_rx = rx_cnt; b_ferr = ferr_cnt; b_q = rxq.size();
    for (int i = 0; i < 10; i++) words[i] = (32'h01010101 * i) ^ 32'h9E3779B9;
    ss_in = 1'b0;
    tick(2);
    for (int i = 0; i < 10; i++) spi_bits(words[i], 32, 2, r0);
    tick(2);
    ss_in = 1'b1;
    tick(8);
    check("b2b_rx_count", rx_cnt - b_rx, 10);
    check("b2b_frame_err", ferr_cnt - b_ferr, 0);
    for (int i = 0; i < 10; i++) check($sformatf("b2b_word%0d", i), rxq[b_q+i], words[i]);

    // Select released after 17 bits
    b_rx = rx_cnt; b_ferr = ferr_cnt;
    ss_in = 1'b0;
    tick(2);
    spi_bits(32'hDEADBEEF, 17, 2, r0);
    tick(2);
    ss_in = 1'b1;
    tick(8);
    check("partial_frame_err", ferr_cnt - b_ferr, 1);
    check("partial_no_rx", rx_cnt - b_rx, 0);
    check("partial_idle", {31'b0, busy}, 0);
    frame1(32'h0BADF00D, 2);
    check("after_partial_count", rx_cnt - b_rx, 1);
    check("after_partial_word", rx_data, 32'h0BADF00D);

    // All-ones word
    b_rx = rx_cnt; b_eos = eos_cnt;
    frame1(32'hFFFFFFFF, 2);
`ifdef SPI_SLAVE_EOS_DETECT_EN
    check("ones_eos_count", eos_cnt - b_eos, 1);
    check("ones_rx_count", rx_cnt - b_rx, 0);
    check("ones_rx_data", rx_data, 32'h0BADF00D);
`else
    check("ones_eos_count", eos_cnt - b_eos, 0);
    check("ones_rx_count", rx_cnt - b_rx, 1);
    check("ones_rx_data", rx_data, 32'hFFFFFFFF);
`endif

    // Reset mid-transfer with select still held low
    ss_in = 1'b0;
    tick(2);
    spi_bits(32'h3C3C3C3C, 10, 2, r0);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    b_rx = rx_cnt; b_ferr = ferr_cnt;
    tick(2);
    check("midreset_busy", {31'b0, busy}, 0);
    check("midreset_rx_data", rx_data, 32'h0);
    spi_bits(32'h55AA55AA, 32, 2, r0);
    tick(4);
    check("midreset_ignored_rx", rx_cnt - b_rx, 0);
    ss_in = 1'b1;
    tick(8);
    check("midreset_no_ferr", ferr_cnt - b_ferr, 0);
    frame1(32'h13579BDF, 2);
    check("midreset_recover_count", rx_cnt - b_rx, 1);
    check("midreset_recover_word", rx_data, 32'h13579BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
